traffic_ctrl_nlane: RTL and testbench

- Parametrised successor of the two-lane traffic light top level. Drives NUM_LANES approaches in round-robin order, each lane getting green in turn.
- Auto, manual and config modes are kept. An all-red clearance phase is inserted between lanes.
- A per-lane "seconds until change/green" countdown feeds the existing seven-segment decoders.
- All control is synchronous to clk; button inputs are single-cycle pulses from the upstream debouncer.

---
 rtl/traffic_ctrl_nlane.sv | 244 ++++++++++++++++++++++++
 tb/tb_traffic_ctrl_nlane.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/traffic_ctrl_nlane.sv
// N-lane round-robin traffic light controller with AUTO / MANUAL / CONFIG modes.
//
// Phase FSM
//   state     | meaning
//   PH_GREEN  | active lane shows green, rem counts down (frozen in MANUAL)
//   PH_YELLOW | active lane shows yellow, rem counts down
//   PH_ALLRED | every lane red, clearance before the next lane's green
//
// Mode FSM
//   state       | meaning
//   MODE_AUTO   | phases advance on the seconds tick
//   MODE_MANUAL | green held until btn_next, remaining phases timed
//   MODE_CONFIG | phase held, lane0/lane1 repurposed as edit display
module traffic_ctrl_nlane #(
    parameter int NUM_LANES     = 2,
    parameter int TIME_W        = 7,
    parameter int TICKS_PER_SEC = 125000000,
    parameter int GREEN_DEF     = 25,
    parameter int YELLOW_DEF    = 3,
    parameter int ALL_RED       = 1,
    parameter int TIME_MAX      = 99
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_btn_mode,
    input  logic                          i_btn_config,
    input  logic                          i_btn_next,
    input  logic                          i_btn_inc,
    input  logic                          i_btn_dec,
    input  logic                          i_btn_confirm,
    output logic [3*NUM_LANES-1:0]        o_lane_light,
    output logic [TIME_W*NUM_LANES-1:0]   o_lane_time,
    output logic [1:0]                    o_mode,
    output logic [TIME_W-1:0]             o_green_time,
    output logic [TIME_W-1:0]             o_yellow_time
);

    localparam int LANE_W  = (NUM_LANES > 2) ? 2 : 1;
    localparam int PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    // Wide enough for rem + two phases + three full lane cycles without overflow.
    localparam int SUM_W   = TIME_W + 4;

    localparam logic [2:0] LIGHT_R = 3'b100;
    localparam logic [2:0] LIGHT_Y = 3'b010;
    localparam logic [2:0] LIGHT_G = 3'b001;

    typedef enum logic [1:0] {MODE_AUTO = 2'b00, MODE_MANUAL = 2'b01, MODE_CONFIG = 2'b10} mode_t;
    typedef enum logic [1:0] {PH_GREEN, PH_YELLOW, PH_ALLRED} phase_t;
    typedef enum logic {FLD_GREEN, FLD_YELLOW} field_t;

    mode_t               r_mode, w_mode_nxt;
    phase_t              r_phase, w_phase_nxt;
    field_t              r_field, w_field_nxt;
    logic [TIME_W-1:0]   r_rem, w_rem_nxt;
    logic [TIME_W-1:0]   r_green_time, w_green_nxt;
    logic [TIME_W-1:0]   r_yellow_time, w_yellow_nxt;
    logic [TIME_W-1:0]   r_edit_g, w_edit_g_nxt;
    logic [TIME_W-1:0]   r_edit_y, w_edit_y_nxt;
    logic [LANE_W-1:0]   r_active, w_active_nxt;
    logic [PRESC_W-1:0]  r_presc, w_presc_nxt;

    logic                w_sec;
    logic                w_enter_cfg;
    logic                w_count;
    logic [LANE_W-1:0]   w_lane_next;
    logic [LANE_W-1:0]   w_ref;
    logic [TIME_W-1:0]   w_edit_sel;
    logic [SUM_W-1:0]    w_cycle;
    logic [SUM_W-1:0]    w_wait0;
    logic [SUM_W-1:0]    w_wait;
    int                  w_dist;

    function automatic logic [TIME_W-1:0] f_inc(input logic [TIME_W-1:0] v);
        return (v >= TIME_W'(TIME_MAX)) ? TIME_W'(TIME_MAX) : v + TIME_W'(1);
    endfunction

    function automatic logic [TIME_W-1:0] f_dec(input logic [TIME_W-1:0] v);
        return (v <= TIME_W'(1)) ? TIME_W'(1) : v - TIME_W'(1);
    endfunction

    assign w_sec       = (r_presc == PRESC_W'(TICKS_PER_SEC - 1));
    assign w_lane_next = (r_active == LANE_W'(NUM_LANES - 1)) ? '0 : r_active + LANE_W'(1);
    assign w_enter_cfg = (r_mode == MODE_AUTO) && !i_btn_mode && i_btn_config;
    // Timing runs in AUTO, and in MANUAL everywhere except the held green.
    assign w_count     = ((r_mode == MODE_AUTO) && !w_enter_cfg) ||
                         ((r_mode == MODE_MANUAL) && (r_phase != PH_GREEN));
    assign w_edit_sel  = (r_field == FLD_GREEN) ? r_edit_g : r_edit_y;

    assign o_mode        = r_mode;
    assign o_green_time  = r_green_time;
    assign o_yellow_time = r_yellow_time;

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mode        <= MODE_AUTO;
            r_phase       <= PH_ALLRED;
            r_rem         <= TIME_W'(ALL_RED);
            r_active      <= LANE_W'(NUM_LANES - 1);
            r_green_time  <= TIME_W'(GREEN_DEF);
            r_yellow_time <= TIME_W'(YELLOW_DEF);
            r_edit_g      <= TIME_W'(GREEN_DEF);
            r_edit_y      <= TIME_W'(YELLOW_DEF);
            r_field       <= FLD_GREEN;
            r_presc       <= '0;
        end else begin
            r_mode        <= w_mode_nxt;
            r_phase       <= w_phase_nxt;
            r_rem         <= w_rem_nxt;
            r_active      <= w_active_nxt;
            r_green_time  <= w_green_nxt;
            r_yellow_time <= w_yellow_nxt;
            r_edit_g      <= w_edit_g_nxt;
            r_edit_y      <= w_edit_y_nxt;
            r_field       <= w_field_nxt;
            r_presc       <= w_presc_nxt;
        end
    end

    // Next-state: phase timing first, then mode handling (config exit overrides phase).
    always_comb begin
        w_mode_nxt   = r_mode;
        w_phase_nxt  = r_phase;
        w_rem_nxt    = r_rem;
        w_active_nxt = r_active;
        w_green_nxt  = r_green_time;
        w_yellow_nxt = r_yellow_time;
        w_edit_g_nxt = r_edit_g;
        w_edit_y_nxt = r_edit_y;
        w_field_nxt  = r_field;
        w_presc_nxt  = r_presc;

        if (w_count) begin
            if (w_sec) begin
                w_presc_nxt = '0;
                if (r_rem > TIME_W'(1)) begin
                    w_rem_nxt = r_rem - TIME_W'(1);
                end else begin
                    case (r_phase)
                        PH_GREEN: begin
                            w_phase_nxt = PH_YELLOW;
                            w_rem_nxt   = r_yellow_time;
                        end
                        PH_YELLOW: begin
                            w_phase_nxt = PH_ALLRED;
                            w_rem_nxt   = TIME_W'(ALL_RED);
                        end
                        default: begin
                            w_phase_nxt  = PH_GREEN;
                            w_rem_nxt    = r_green_time;
                            w_active_nxt = w_lane_next;
                        end
                    endcase
                end
            end else begin
                w_presc_nxt = r_presc + PRESC_W'(1);
            end
        end else if (r_mode == MODE_MANUAL) begin
            // Held green: keep the prescaler cleared so a resume starts a full second.
            w_presc_nxt = '0;
            if (i_btn_next) begin
                w_phase_nxt = PH_YELLOW;
                w_rem_nxt   = r_yellow_time;
            end
        end

        case (r_mode)
            MODE_AUTO: begin
                if (i_btn_mode) begin
                    w_mode_nxt = MODE_MANUAL;
                end else if (i_btn_config) begin
                    w_mode_nxt   = MODE_CONFIG;
                    w_edit_g_nxt = r_green_time;
                    w_edit_y_nxt = r_yellow_time;
                    w_field_nxt  = FLD_GREEN;
                end
            end
            MODE_MANUAL: begin
                if (i_btn_mode) w_mode_nxt = MODE_AUTO;
            end
            MODE_CONFIG: begin
                if (i_btn_next) w_field_nxt = (r_field == FLD_GREEN) ? FLD_YELLOW : FLD_GREEN;
                if (i_btn_inc && !i_btn_dec) begin
                    if (r_field == FLD_GREEN) w_edit_g_nxt = f_inc(r_edit_g);
                    else                      w_edit_y_nxt = f_inc(r_edit_y);
                end
                if (i_btn_dec && !i_btn_inc) begin
                    if (r_field == FLD_GREEN) w_edit_g_nxt = f_dec(r_edit_g);
                    else                      w_edit_y_nxt = f_dec(r_edit_y);
                end
                if (i_btn_confirm) begin
                    w_green_nxt  = r_edit_g;
                    w_yellow_nxt = r_edit_y;
                end
                if (i_btn_config) begin
                    w_mode_nxt  = MODE_AUTO;
                    w_phase_nxt = PH_ALLRED;
                    w_rem_nxt   = TIME_W'(ALL_RED);
                    w_presc_nxt = '0;
                end
            end
            default: w_mode_nxt = MODE_AUTO;
        endcase
    end

    // Lights and per-lane countdown display.
    always_comb begin
        o_lane_light = '0;
        o_lane_time  = '0;
        w_dist       = 0;
        w_wait       = '0;
        // In clearance the countdown is referenced to the lane about to go green.
        w_ref   = (r_phase == PH_ALLRED) ? w_lane_next : r_active;
        w_cycle = SUM_W'(r_green_time) + SUM_W'(r_yellow_time) + SUM_W'(ALL_RED);
        case (r_phase)
            PH_GREEN:  w_wait0 = SUM_W'(r_rem) + SUM_W'(r_yellow_time) + SUM_W'(ALL_RED);
            PH_YELLOW: w_wait0 = SUM_W'(r_rem) + SUM_W'(ALL_RED);
            default:   w_wait0 = SUM_W'(r_rem) + w_cycle;
        endcase

        for (int k = 0; k < NUM_LANES; k++) begin
            w_dist = k - int'(w_ref) - 1;
            if (w_dist < 0) w_dist = w_dist + NUM_LANES;
            w_wait = w_wait0 + SUM_W'(w_dist) * w_cycle;
            if (k == int'(w_ref)) w_wait = SUM_W'(r_rem);

            o_lane_light[3*k +: 3] = LIGHT_R;
            if (r_mode == MODE_CONFIG) begin
                if (k == 0) begin
                    o_lane_light[3*k +: 3]          = (r_field == FLD_GREEN) ? LIGHT_G : LIGHT_Y;
                    o_lane_time[TIME_W*k +: TIME_W] = w_edit_sel;
                end else if (k == 1) begin
                    o_lane_time[TIME_W*k +: TIME_W] = (r_field == FLD_GREEN) ? TIME_W'(1) : TIME_W'(2);
                end
            end else begin
                if ((r_phase != PH_ALLRED) && (k == int'(r_active)))
                    o_lane_light[3*k +: 3] = (r_phase == PH_GREEN) ? LIGHT_G : LIGHT_Y;
                if (r_mode == MODE_AUTO)
                    o_lane_time[TIME_W*k +: TIME_W] = (|w_wait[SUM_W-1:TIME_W]) ? '1 : w_wait[TIME_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_traffic_ctrl_nlane.sv
// Directed bench for traffic_ctrl_nlane with 3 lanes, 4 ticks per second, G=5 Y=2 AR=1.
module tb_traffic_ctrl_nlane;

    localparam int N  = 3;
    localparam int TW = 7;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;
    localparam logic [8:0] ALLR = {R, R, R};
    localparam logic [8:0] L0G  = {R, R, G};
    localparam logic [8:0] L0Y  = {R, R, Y};
    localparam logic [8:0] L1G  = {R, G, R};
    localparam logic [8:0] L1Y  = {R, Y, R};
    localparam logic [8:0] L2G  = {G, R, R};
    localparam logic [8:0] L2Y  = {Y, R, R};

    localparam logic [5:0] B_MODE = 6'b100000;
    localparam logic [5:0] B_CFG  = 6'b010000;
    localparam logic [5:0] B_NEXT = 6'b001000;
    localparam logic [5:0] B_INC  = 6'b000100;
    localparam logic [5:0] B_DEC  = 6'b000010;
    localparam logic [5:0] B_CONF = 6'b000001;

    logic            clk = 1'b0;
    logic            reset;
    logic            btn_mode, btn_config, btn_next, btn_inc, btn_dec, btn_confirm;
    logic [3*N-1:0]  lane_light;
    logic [TW*N-1:0] lane_time;
    logic [1:0]      mode;
    logic [TW-1:0]   green_time, yellow_time;

    int n_checks = 0;
    int n_fail   = 0;

    traffic_ctrl_nlane #(
        .NUM_LANES(N), .TIME_W(TW), .TICKS_PER_SEC(4),
        .GREEN_DEF(5), .YELLOW_DEF(2), .ALL_RED(1), .TIME_MAX(99)
    ) dut (
        .i_clk(clk), .i_reset(reset),
        .i_btn_mode(btn_mode), .i_btn_config(btn_config), .i_btn_next(btn_next),
        .i_btn_inc(btn_inc), .i_btn_dec(btn_dec), .i_btn_confirm(btn_confirm),
        .o_lane_light(lane_light), .o_lane_time(lane_time), .o_mode(mode),
        .o_green_time(green_time), .o_yellow_time(yellow_time)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [TW*N-1:0] lt(input int l0, input int l1, input int l2);
        return {TW'(l2), TW'(l1), TW'(l0)};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [5:0] b);
        {btn_mode, btn_config, btn_next, btn_inc, btn_dec, btn_confirm} = b;
        @(negedge clk);
        {btn_mode, btn_config, btn_next, btn_inc, btn_dec, btn_confirm} = '0;
    endtask

    // Checks the lights on n consecutive cycles, ending one cycle later.
    task automatic expect_lights(input string tag, input logic [8:0] exp, input int n);
        for (int i = 0; i < n; i++) begin
            check_val(tag, 32'(lane_light), 32'(exp));
            tick(1);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_light"}, 32'(lane_light), 32'(ALLR));
        check_val({tag, "_mode"},  32'(mode), 32'd0);
        check_val({tag, "_green"}, 32'(green_time), 32'd5);
        check_val({tag, "_yellow"}, 32'(yellow_time), 32'd2);
        check_val({tag, "_time"},  32'(lane_time), 32'(lt(1, 9, 17)));
    endtask

    initial begin
        reset = 1'b1;
        {btn_mode, btn_config, btn_next, btn_inc, btn_dec, btn_confirm} = '0;
        tick(3);
        reset = 1'b0;

        // Power-up sequence
        check_reset_state("rst");
        expect_lights("s1_allred", ALLR, 4);
        check_val("s1_time_g_entry", 32'(lane_time), 32'(lt(5, 8, 16)));
        expect_lights("s1_l0g", L0G, 20);
        expect_lights("s1_l0y", L0Y, 8);
        expect_lights("s1_allred2", ALLR, 4);

        // lane1 green, manual hold from rem=3
        tick(8);
        check_val("s2_l1g", 32'(lane_light), 32'(L1G));
        check_val("s2_time_rem3", 32'(lane_time), 32'(lt(14, 3, 6)));
        press(B_MODE);
        check_val("s2_mode_manual", 32'(mode), 32'd1);
        check_val("s2_time_zero", 32'(lane_time), 32'd0);
        expect_lights("s2_hold", L1G, 40);
        check_val("s2_time_zero_end", 32'(lane_time), 32'd0);
        press(B_NEXT);
        expect_lights("s2_l1y", L1Y, 8);
        expect_lights("s2_allred", ALLR, 4);
        expect_lights("s2_l2g_hold", L2G, 10);

        // Config ignored in manual, back to auto, then edit and commit
        press(B_CFG);
        check_val("s3_cfg_ignored", 32'(mode), 32'd1);
        press(B_MODE);
        check_val("s3_mode_auto", 32'(mode), 32'd0);
        press(B_CFG);
        check_val("s3_mode_cfg", 32'(mode), 32'd2);
        check_val("s3_cfg_light_g", 32'(lane_light), 32'(L0G));
        check_val("s3_cfg_time", 32'(lane_time), 32'(lt(5, 1, 0)));
        repeat (3) press(B_INC);
        check_val("s3_inc", 32'(lane_time), 32'(lt(8, 1, 0)));
        check_val("s3_green_uncommitted", 32'(green_time), 32'd5);
        press(B_NEXT);
        check_val("s3_cfg_light_y", 32'(lane_light), 32'(L0Y));
        check_val("s3_field_y", 32'(lane_time), 32'(lt(2, 2, 0)));
        repeat (5) press(B_DEC);
        check_val("s3_dec_clamp", 32'(lane_time), 32'(lt(1, 2, 0)));
        press(B_CONF);
        check_val("s3_green_commit", 32'(green_time), 32'd8);
        check_val("s3_yellow_commit", 32'(yellow_time), 32'd1);
        press(B_CFG);
        check_val("s3_exit_mode", 32'(mode), 32'd0);
        check_val("s3_exit_time", 32'(lane_time), 32'(lt(1, 11, 21)));
        expect_lights("s3_allred", ALLR, 4);
        expect_lights("s3_l0g", L0G, 32);
        expect_lights("s3_l0y", L0Y, 4);
        expect_lights("s3_allred2", ALLR, 4);
        expect_lights("s3_l1g", L1G, 32);
        expect_lights("s3_l1y", L1Y, 4);
        expect_lights("s3_allred3", ALLR, 4);
        expect_lights("s3_l2g", L2G, 32);
        expect_lights("s3_l2y", L2Y, 2);

        // Reset mid-yellow
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check_reset_state("s6_rst");
        expect_lights("s6_allred", ALLR, 4);
        check_val("s6_time_g_entry", 32'(lane_time), 32'(lt(5, 8, 16)));
        expect_lights("s6_l0g", L0G, 20);
        expect_lights("s6_l0y", L0Y, 8);

        // Edits discarded without confirm
        press(B_CFG);
        repeat (2) press(B_INC);
        check_val("s4_edit", 32'(lane_time), 32'(lt(7, 1, 0)));
        press(B_CFG);
        check_val("s4_green_kept", 32'(green_time), 32'd5);
        press(B_CFG);
        check_val("s4_reentry", 32'(lane_time), 32'(lt(5, 1, 0)));

        // Simultaneous buttons
        press(B_INC | B_DEC);
        check_val("s5_inc_dec", 32'(lane_time), 32'(lt(5, 1, 0)));
        press(B_CFG);
        check_val("s5_auto", 32'(mode), 32'd0);
        press(B_MODE | B_CFG);
        check_val("s5_mode_wins", 32'(mode), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
